rs_scheduler: RTL and testbench
===============================

# rs_scheduler

Allocation and issue controller for the reservation station array. It picks a free RS entry for each dispatched instruction and drives that entry's write enable. Each cycle it grants, per functional-unit channel, the oldest ready entry whose FU can accept, then clears granted entries. It sits between the dispatch logic, the RS entry array and the issue-stage pipeline register.

## Interface
- `RS_LEN`, 8: number of RS entries; power of two, at least 2.
- `N_CH`, 4: number of FU channels; channel codes are 0..N_CH-1.
- `IDX_W`, $clog2(RS_LEN): entry index width.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `squash` in 1: synchronous flush of all scheduler state.
- `dispatch_valid` in 1: the dispatch logic presents an instruction this cycle.
- `dispatch_ready` out 1: a free entry exists; dispatch fires when valid && ready.
- `entry_wr_en` out RS_LEN: one-hot write enable to the chosen entry; all zero if no fire.
- `entry_busy` in RS_LEN: busy flags from the entries.
- `entry_ready` in RS_LEN: operand-ready flags from the entries, including CDB forwarding.
- `entry_channel` in RS_LEN x CH_W: channel code held by each entry.
- `fu_ready` in N_CH: the FU of that channel accepts an issue this cycle.
- `grant_valid` out N_CH: combinational issue grant per channel.
- `grant_idx` out N_CH x IDX_W: granted entry index per channel; 0 when not valid.
- `entry_clear` out RS_LEN: OR of all grants as a one-hot mask; frees entries at the next edge.
- `issue_valid_q` out N_CH: grant_valid registered one cycle.
- `issue_idx_q` out N_CH x IDX_W: grant_idx registered one cycle.
- `occupancy` out IDX_W+1: registered count of allocated entries.

## Operation
**Allocation**
- The free set is ~entry_busy as sampled this cycle. An entry cleared this cycle is not reusable until the next cycle.
- Registered pointer `alloc_ptr` selects the first free entry scanning alloc_ptr, alloc_ptr+1, … modulo RS_LEN.
- On fire, `alloc_ptr` is set to (chosen+1) mod RS_LEN.
- dispatch_ready = |free && !squash.

**Age tracking**
- Registered RS_LEN x RS_LEN matrix `older`, where older[i][j]=1 means entry i is older than entry j.
- On allocation of entry k: row k is set to 0, and column k is set to 1 for every j≠k.
- Rows and columns of freed entries are left stale; they are ignored because candidates must be busy.

**Issue selection, per channel c**
- cand[i] = entry_busy[i] && entry_ready[i] && entry_channel[i]==c && fu_ready[c].
- The grant goes to the unique i with cand[i] such that no j has cand[j] && older[j][i].
- Each entry holds exactly one channel code, so grants are disjoint across channels.
- While squash is high, all grants are forced to 0.

**Occupancy**
- occupancy_next = occupancy + fire − popcount(entry_clear).
- occupancy must always equal popcount(entry_busy) from the previous cycle's view. The bench checks this with an assertion.

**Squash**
- At the next edge: older is cleared, alloc_ptr=0, occupancy=0, issue_valid_q=0.
- During the squash cycle: entry_wr_en=0 and entry_clear=0. The entries flush themselves on the same squash.

## Timing
- Reset (reset_n low, asynchronous) sets:
  - alloc_ptr=0, older=0, occupancy=0;
  - issue_valid_q=0, issue_idx_q=0.
- Combinational outputs follow their inputs: dispatch_ready=1 when no entry is busy; grants are 0 when no entry is busy.
- Dispatch to entry: entry_wr_en is combinational in cycle t, and the entry is busy from t+1.
- Earliest grant for that entry is in t+1. The entry's own ready logic covers a CDB match in t+1.
- Grant to clear: entry_clear is asserted in cycle t, and the entry is free at t+1.
- The RS top muxes the entry's packet using grant_idx in cycle t. issue_valid_q and issue_idx_q are visible in t+1.
- fu_ready low: no grant for that channel. The entry stays ready and competes again next cycle; there is no starvation because age order is fixed.
- Full (occupancy==RS_LEN): dispatch_ready=0 even if a clear occurs the same cycle.
- Simultaneous dispatch and clear of different entries: both take effect, and occupancy nets them.
- Reset mid-operation: all state returns to reset values immediately. In-flight grants are dropped.

## Structure
- Shared package `sys_defs.svh` holds:
  - the CH_W constant;
  - the channel enum (ALU, MULT, LOAD, STORE, reusing the existing channel type);
  - a typedef for the per-channel grant struct {valid, idx}.
- Sub-module `rs_age_picker` is natural: one instance per channel. Inputs are cand and older; outputs are a one-hot grant and an encoded idx.
- The top module adds the allocation pointer, the occupancy counter and the output registers.

## Test plan
- **Reset:** with reset_n=0 mid-run, the bench checks occupancy=0, issue_valid_q=0 and dispatch_ready=1 after release.
- **Round-robin allocation:** 8 back-to-back dispatches with none issued → entry_wr_en one-hot at 0,1,…,7. Then dispatch_ready=0 and occupancy=8.
- **Age order:**
  - Setup: allocate entries 2, 5, 1, all channel ALU, with all ready in the same cycle.
  - Expect: grant_idx[ALU] sequence 2, 5, 1 over three cycles, and issue_idx_q lagging by one cycle.
- **Per-channel parallelism:** entry 0 is ALU, entry 3 is MULT, both ready. Expect both grant_valid=1 in the same cycle and entry_clear=0b00001001.
- **FU backpressure:** entry 4 (LOAD) is ready while fu_ready[LOAD]=0 for 3 cycles. Expect no grant for those cycles, then a grant in the cycle fu_ready rises.
- **Full plus simultaneous clear, then squash:**
  - Full with entry 6 granted: dispatch_ready=0 that cycle, then dispatch to entry 6 the next cycle.
  - Squash: all grants are 0, and the next cycle shows occupancy=0 and alloc_ptr=0 (first dispatch goes to entry 0).

Source files
------------

// File: rtl/rs_scheduler_pkg.sv
// rs_scheduler_pkg: channel codes and per-channel grant type shared by the RS scheduler
package rs_scheduler_pkg;
  localparam int CH_W = 2;
  localparam int RS_IDX_W = 3;
  typedef enum logic [CH_W-1:0] {CH_ALU, CH_MULT, CH_LOAD, CH_STORE} channel_e;
  typedef struct packed {
    logic                valid;
    logic [RS_IDX_W-1:0] idx;
  } grant_t;
endpackage

// File: rtl/rs_age_picker.sv
// rs_age_picker: grants the candidate that no other candidate is older than
module rs_age_picker #(
  parameter int RS_LEN = 8,
  parameter int IDX_W  = $clog2(RS_LEN)
) (
  input  logic [RS_LEN-1:0]             cand,
  input  logic [RS_LEN-1:0][RS_LEN-1:0] older,
  output logic [RS_LEN-1:0]             grant,
  output logic [IDX_W-1:0]              idx
);
  for (genvar i = 0; i < RS_LEN; i++) begin : g_ent
    logic [RS_LEN-1:0] col;
    for (genvar j = 0; j < RS_LEN; j++) begin : g_col
      assign col[j] = older[j][i];
    end
    assign grant[i] = cand[i] & ~|(cand & col);
  end
  always_comb begin
    idx = '0;
    for (int i = 0; i < RS_LEN; i++) idx |= grant[i] ? IDX_W'(i) : '0;
  end
endmodule

// File: rtl/rs_scheduler.sv
// rs_scheduler: RS entry allocation and oldest-ready issue selection per FU channel
module rs_scheduler
  import rs_scheduler_pkg::*;
#(
  parameter int RS_LEN = 8,
  parameter int N_CH   = 4,
  parameter int IDX_W  = $clog2(RS_LEN)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             squash,
  input  logic                             dispatch_valid,
  output logic                             dispatch_ready,
  output logic [RS_LEN-1:0]                entry_wr_en,
  input  logic [RS_LEN-1:0]                entry_busy,
  input  logic [RS_LEN-1:0]                entry_ready,
  input  logic [RS_LEN-1:0][CH_W-1:0]      entry_channel,
  input  logic [N_CH-1:0]                  fu_ready,
  output logic [N_CH-1:0]                  grant_valid,
  output logic [N_CH-1:0][IDX_W-1:0]       grant_idx,
  output logic [RS_LEN-1:0]                entry_clear,
  output logic [N_CH-1:0]                  issue_valid_q,
  output logic [N_CH-1:0][IDX_W-1:0]       issue_idx_q,
  output logic [IDX_W:0]                   occupancy
);
  logic [IDX_W-1:0]              alloc_ptr_q, alloc_ptr_d, pick;
  logic [RS_LEN-1:0][RS_LEN-1:0] older_q, older_d;
  logic [IDX_W:0]                occ_q, occ_d, n_clr;
  logic [N_CH-1:0]               issue_valid_d;
  logic [N_CH-1:0][IDX_W-1:0]    issue_idx_d;
  logic [N_CH-1:0][RS_LEN-1:0]   cand, grant;
  logic [RS_LEN-1:0]             free;
  logic                          fire;
  assign free = ~entry_busy;
  // scan downwards so the free entry closest to alloc_ptr wins
  always_comb begin
    pick = '0;
    for (int k = RS_LEN - 1; k >= 0; k--)
      if (free[alloc_ptr_q + IDX_W'(k)]) pick = alloc_ptr_q + IDX_W'(k);
  end
  assign dispatch_ready = |free && !squash;
  assign fire           = dispatch_valid && dispatch_ready;
  assign entry_wr_en    = fire ? RS_LEN'(1) << pick : '0;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    for (genvar i = 0; i < RS_LEN; i++) begin : g_cand
      assign cand[c][i] = entry_busy[i] && entry_ready[i] && entry_channel[i] == CH_W'(c) &&
                          fu_ready[c] && !squash;
    end
    rs_age_picker #(.RS_LEN(RS_LEN), .IDX_W(IDX_W)) u_pick (
      .cand  (cand[c]),
      .older (older_q),
      .grant (grant[c]),
      .idx   (grant_idx[c])
    );
    assign grant_valid[c] = |grant[c];
  end
  always_comb begin
    entry_clear = '0;
    n_clr       = '0;
    for (int c = 0; c < N_CH; c++) entry_clear |= grant[c];
    for (int i = 0; i < RS_LEN; i++) n_clr += (IDX_W+1)'(entry_clear[i]);
  end
  // a new entry is younger than everything; stale rows of free entries never matter
  always_comb begin
    older_d = older_q;
    if (squash) older_d = '0;
    else if (fire)
      for (int j = 0; j < RS_LEN; j++) begin
        older_d[pick][j] = 1'b0;
        older_d[j][pick] = IDX_W'(j) != pick;
      end
  end
  assign alloc_ptr_d   = squash ? '0 : fire ? pick + IDX_W'(1) : alloc_ptr_q;
  assign occ_d         = squash ? '0 : occ_q + (IDX_W+1)'(fire) - n_clr;
  assign issue_valid_d = grant_valid;
  assign issue_idx_d   = grant_idx;
  assign occupancy     = occ_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alloc_ptr_q   <= '0;
      older_q       <= '0;
      occ_q         <= '0;
      issue_valid_q <= '0;
      issue_idx_q   <= '0;
    end else begin
      alloc_ptr_q   <= alloc_ptr_d;
      older_q       <= older_d;
      occ_q         <= occ_d;
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
    end
  end
endmodule

// File: tb/tb_rs_scheduler.sv
// tb_rs_scheduler: bench acting as the RS entry array, checked against an age-ordered reference model
module tb_rs_scheduler;
  import rs_scheduler_pkg::*;
  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            sq = 1'b0, dv = 1'b0;
  logic            dispatch_ready;
  logic [7:0]      entry_wr_en, entry_clear;
  logic [7:0]      busy = '0, rdy = '0;
  logic [7:0][1:0] chan = '0;
  logic [3:0]      fu = '0, grant_valid, issue_valid_q;
  logic [3:0][2:0] grant_idx, issue_idx_q;
  logic [3:0]      occupancy;
  int              n_chk = 0, n_pass = 0;
  int              mptr = 0, mocc = 0, gseq = 0, e_pick;
  int              seq[8];
  channel_e        d_ch = CH_ALU;
  logic            d_rdy = 1'b0, wake_en = 1'b0, e_fire;
  logic [7:0]      e_wr, e_clr;
  grant_t          eg[4];
  rs_scheduler dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .squash         (sq),
    .dispatch_valid (dv),
    .dispatch_ready (dispatch_ready),
    .entry_wr_en    (entry_wr_en),
    .entry_busy     (busy),
    .entry_ready    (rdy),
    .entry_channel  (chan),
    .fu_ready       (fu),
    .grant_valid    (grant_valid),
    .grant_idx      (grant_idx),
    .entry_clear    (entry_clear),
    .issue_valid_q  (issue_valid_q),
    .issue_idx_q    (issue_idx_q),
    .occupancy      (occupancy)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic model_comb();
    int best;
    e_pick = -1;
    for (int k = 0; k < 8; k++) if (e_pick < 0 && !busy[(mptr + k) % 8]) e_pick = (mptr + k) % 8;
    e_fire = dv && e_pick >= 0 && !sq;
    e_wr   = e_fire ? 8'(1) << e_pick : 8'h00;
    e_clr  = '0;
    for (int c = 0; c < 4; c++) begin
      eg[c] = '0;
      best  = -1;
      for (int i = 0; i < 8; i++)
        if (busy[i] && rdy[i] && chan[i] == 2'(c) && fu[c] && !sq && (best < 0 || seq[i] < seq[best]))
          best = i;
      if (best >= 0) begin
        eg[c].valid = 1'b1;
        eg[c].idx   = 3'(best);
        e_clr[best] = 1'b1;
      end
    end
  endtask
  task automatic cycle();
    logic [3:0]      gv;
    logic [3:0][2:0] gi;
    #1;
    model_comb();
    for (int c = 0; c < 4; c++) begin
      gv[c] = eg[c].valid;
      gi[c] = eg[c].idx;
    end
    check("drdy", dispatch_ready, e_pick >= 0 && !sq);
    check("wr", entry_wr_en, e_wr);
    check("gv", grant_valid, gv);
    check("gi", grant_idx, gi);
    check("clr", entry_clear, e_clr);
    @(posedge clock);
    #1;
    if (sq) begin
      busy = '0;
      rdy  = '0;
      mptr = 0;
      mocc = 0;
    end else begin
      busy &= ~e_clr;
      rdy  &= ~e_clr;
      mocc -= $countones(e_clr);
      if (e_fire) begin
        busy[e_pick] = 1'b1;
        rdy[e_pick]  = d_rdy;
        chan[e_pick] = d_ch;
        seq[e_pick]  = gseq;
        gseq++;
        mptr = (e_pick + 1) % 8;
        mocc++;
      end
    end
    if (wake_en) rdy |= busy & 8'($urandom);
    check("occ", occupancy, mocc);
    check("occ_busy", occupancy, $countones(busy));
    check("iv", issue_valid_q, gv);
    check("ii", issue_idx_q, gi);
  endtask
  task automatic drv(input logic v, input channel_e ch, input logic r, input logic [3:0] f, input logic s);
    dv    = v;
    d_ch  = ch;
    d_rdy = r;
    fu    = f;
    sq    = s;
  endtask
  task automatic disp(input channel_e ch, input logic r);
    drv(1'b1, ch, r, 4'b0000, 1'b0);
    cycle();
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    drv(1'b0, CH_ALU, 1'b0, 4'b0000, 1'b0);
    #2;
    check("rst_occ", occupancy, 0);
    check("rst_iv", issue_valid_q, 0);
    check("rst_ii", issue_idx_q, 0);
    busy = '0;
    rdy  = '0;
    mptr = 0;
    mocc = 0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst_drdy", dispatch_ready, 1);
    @(posedge clock);
    #1;
  endtask
  initial begin
    channel_e age_ch[8] = '{CH_STORE, CH_MULT, CH_ALU, CH_STORE, CH_STORE, CH_ALU, CH_STORE, CH_STORE};
    int ord[3] = '{2, 5, 1};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drv(1'b1, CH_STORE, 1'b0, 4'b0000, 1'b0);
      #1;
      check("rr_wr", entry_wr_en, 8'(1) << k);
      cycle();
    end
    drv(1'b1, CH_STORE, 1'b0, 4'b0000, 1'b0);
    #1;
    check("full_drdy", dispatch_ready, 0);
    check("full_occ", occupancy, 8);
    cycle();
    do_reset();
    for (int k = 0; k < 8; k++) disp(age_ch[k], 1'b0);
    rdy[1] = 1'b1;
    drv(1'b0, CH_ALU, 1'b0, 4'b0010, 1'b0);
    cycle();
    drv(1'b1, CH_ALU, 1'b0, 4'b0000, 1'b0);
    #1;
    check("age_alloc", entry_wr_en, 8'h02);
    cycle();
    rdy[1] = 1'b1;
    rdy[2] = 1'b1;
    rdy[5] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drv(1'b0, CH_ALU, 1'b0, 4'b0001, 1'b0);
      #1;
      check("age_gi", grant_idx[0], ord[k]);
      check("age_lag", issue_idx_q[0], k > 0 ? ord[k-1] : 0);
      cycle();
    end
    check("age_lag_end", issue_idx_q[0], 1);
    do_reset();
    disp(CH_ALU, 1'b0);
    disp(CH_STORE, 1'b0);
    disp(CH_STORE, 1'b0);
    disp(CH_MULT, 1'b0);
    rdy[0] = 1'b1;
    rdy[3] = 1'b1;
    drv(1'b0, CH_ALU, 1'b0, 4'b0011, 1'b0);
    #1;
    check("par_gv", grant_valid[1:0], 2'b11);
    check("par_clr", entry_clear, 8'h09);
    cycle();
    do_reset();
    for (int k = 0; k < 4; k++) disp(CH_STORE, 1'b0);
    disp(CH_LOAD, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drv(1'b0, CH_ALU, 1'b0, 4'b1011, 1'b0);
      #1;
      check("bp_hold", grant_valid[2], 0);
      cycle();
    end
    drv(1'b0, CH_ALU, 1'b0, 4'b0100, 1'b0);
    #1;
    check("bp_gv", grant_valid[2], 1);
    check("bp_gi", grant_idx[2], 4);
    cycle();
    do_reset();
    for (int k = 0; k < 8; k++) disp(k == 6 ? CH_ALU : CH_STORE, k == 6);
    drv(1'b1, CH_STORE, 1'b0, 4'b0001, 1'b0);
    #1;
    check("fc_drdy", dispatch_ready, 0);
    check("fc_gi", grant_idx[0], 6);
    check("fc_clr", entry_clear, 8'h40);
    cycle();
    drv(1'b1, CH_STORE, 1'b0, 4'b0000, 1'b0);
    #1;
    check("fc_reuse", entry_wr_en, 8'h40);
    cycle();
    rdy = 8'hff;
    drv(1'b1, CH_ALU, 1'b0, 4'b1111, 1'b1);
    #1;
    check("sq_gv", grant_valid, 0);
    check("sq_wr", entry_wr_en, 0);
    check("sq_clr", entry_clear, 0);
    cycle();
    check("sq_occ", occupancy, 0);
    drv(1'b1, CH_ALU, 1'b0, 4'b0000, 1'b0);
    #1;
    check("sq_ptr", entry_wr_en, 8'h01);
    cycle();
    wake_en = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      drv(($urandom % 4) != 0, channel_e'($urandom_range(0, 3)), 1'($urandom), 4'($urandom),
          ($urandom % 64) == 0);
      cycle();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
